// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first through one full-subtractor
// cell and a registered borrow, behind a start/ready/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic             a_i, b_i, d_i, bout;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    a_i  = a_sh_q[0];
    b_i  = b_sh_q[0];
    d_i  = a_i ^ b_i ^ bin_q;
    bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_i, res_q[WIDTH-1:1]};
        bin_d  = bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // On the last bit the shifters hold the operand MSBs and d_i is the result MSB.
          state_d  = DONE;
          diff_d   = {d_i, res_q[WIDTH-1:1]};
          borrow_d = bout;
          ovf_d    = (a_i ^ b_i) & (d_i ^ a_i);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == BUSY);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule
